// File: rtl/axi_frame_pkg.sv
// Shared AXI encodings, reader FSM states and pixel packing for the frame reader/writer pair.
package axi_frame_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  // Pixel 0 occupies the low word; each pixel is {8'h00, R, G, B}.
  function automatic logic [63:0] pack_pixels(
    input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
    input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1
  );
    return {8'h00, r1, g1, b1, 8'h00, r0, g0, b0};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible on dout_o while valid_o is high.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_s;
  logic             pop_s;

  assign push_s = push_i && (count_q != FULL);
  assign pop_s  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/axi_frame_reader.sv
// AXI3 burst read master streaming a packed RGB frame buffer out as 64-bit AXI4-Stream beats.
module axi_frame_reader
  import axi_frame_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       FRAME_W    = 1920,
  parameter int unsigned       FRAME_H    = 1080,
  parameter logic [ADDR_W-1:0] ADDR_START = 32'h1000_0000,
  parameter int unsigned       BURST_LEN  = 16,
  parameter int unsigned       FIFO_DEPTH = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [3:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              frame_done,
  output logic [1:0]        err_status
);

  localparam int unsigned BURST_BYTES_I = BURST_LEN * DATA_W / 8;
  localparam int unsigned FRAME_BYTES   = FRAME_W * FRAME_H * 4;
  localparam int unsigned NBURSTS       = FRAME_BYTES / BURST_BYTES_I;
  localparam int unsigned BC_W          = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;
  localparam int unsigned BEAT_W        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_BYTES_I);
  localparam logic [BC_W-1:0]   BURST_LAST  = BC_W'(NBURSTS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  ROOM_THR    = CNT_W'(FIFO_DEPTH - BURST_LEN);

  if ((FRAME_BYTES % BURST_BYTES_I) != 0) begin : g_bad_frame
    $error("axi_frame_reader: frame size must be a whole number of bursts");
  end

  rd_state_e         state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BC_W-1:0]   burst_q;
  logic              frame_done_q;
  logic [1:0]        err_q;

  logic              beat_acc_s;
  logic              first_s;
  logic              last_s;
  logic              last_burst_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [DATA_W+1:0] fifo_dout_s;

  assign beat_acc_s   = m_axi_rvalid && rready_q;
  assign last_burst_s = (burst_q == BURST_LAST);
  assign first_s      = (burst_q == '0) && (beat_q == '0);
  assign last_s       = last_burst_s && (beat_q == BEAT_LAST);

  // Single-burst-outstanding read FSM with sticky error tracking.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      araddr_q     <= ADDR_START;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      beat_q       <= '0;
      burst_q      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      frame_done_q <= 1'b0;
      if (beat_acc_s && (m_axi_rresp != AXI_RESP_OKAY)) err_q[0] <= 1'b1;
      if (beat_acc_s && (m_axi_rlast != (beat_q == BEAT_LAST))) err_q[1] <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          beat_q <= '0;
          if (enable && (fifo_count_s <= ROOM_THR)) begin
            state_q   <= ST_ADDR;
            arvalid_q <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_acc_s) begin
            beat_q <= beat_q + BEAT_W'(1);
            // rlast always ends the burst, even when it arrives at the wrong beat.
            if (m_axi_rlast) begin
              state_q  <= ST_IDLE;
              rready_q <= 1'b0;
              beat_q   <= '0;
              if (last_burst_s) begin
                araddr_q     <= ADDR_START;
                burst_q      <= '0;
                frame_done_q <= 1'b1;
              end else begin
                araddr_q <= araddr_q + BURST_BYTES;
                burst_q  <= burst_q + BC_W'(1);
              end
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (beat_acc_s),
    .din_i   ({first_s, last_s, m_axi_rdata}),
    .pop_i   (m_axis_tready),
    .dout_o  (fifo_dout_s),
    .valid_o (m_axis_tvalid),
    .count_o (fifo_count_s)
  );

  assign m_axis_tuser  = fifo_dout_s[DATA_W+1];
  assign m_axis_tlast  = fifo_dout_s[DATA_W];
  assign m_axis_tdata  = fifo_dout_s[DATA_W-1:0];

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_arlen   = 4'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = 4'b0000;
  assign frame_done    = frame_done_q;
  assign err_status    = err_q;

endmodule

// File: tb/tb_axi_frame_reader.sv
// Scoreboard bench: a slave model queues expected stream beats, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_axi_frame_reader;
  import axi_frame_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b1;
  logic [63:0] m_axi_rdata = 64'h0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        frame_done;
  logic [1:0]  err_status;

  always #5 aclk = ~aclk;

  axi_frame_reader #(.FRAME_W(64), .FRAME_H(2)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .frame_done(frame_done), .err_status(err_status)
  );

  typedef struct packed {
    logic        user;
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_ar = 0;
  int          n_rbeats = 0;
  int          n_pops = 0;
  int          n_fd = 0;
  int          ar_pop_snap = 0;
  logic [31:0] last_ar_addr = 32'h0;
  logic [31:0] ar_log [8];
  int          ar_log_n = 0;
  int          exp_idx = 0;
  int          cur_idx = 0;
  int          s_beat = 0;
  logic [31:0] cur_addr = 32'h0;
  bit          s_active = 1'b0;
  bit          fd_exp = 1'b0;
  bit          cfg_fault_once = 1'b0;
  bit          fault_burst = 1'b0;
  bit          fault_done = 1'b0;
  bit          arready_ctl = 1'b1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // AXI read slave: accepts AR, returns bursts, queues the stream beat each accepted R beat should yield.
  initial begin : slave
    bit          ar_hs, r_hs, rst_seen, rlast_s;
    logic [31:0] ar_addr_s;
    forever begin
      @(negedge aclk);
      rst_seen  = areset;
      ar_hs     = !areset && m_axi_arvalid && m_axi_arready;
      r_hs      = !areset && m_axi_rvalid && m_axi_rready;
      ar_addr_s = m_axi_araddr;
      rlast_s   = m_axi_rlast;
      if (r_hs) begin
        exp_q.push_back({(cur_idx == 0 && s_beat == 0), (cur_idx == 3 && s_beat == 15), m_axi_rdata});
        n_rbeats++;
      end
      @(posedge aclk);
      #1;
      fd_exp = 1'b0;
      if (rst_seen) begin
        s_active = 1'b0; s_beat = 0; exp_idx = 0; ar_log_n = 0;
        exp_q.delete();
      end else begin
        if (r_hs) begin
          if (rlast_s) begin
            s_active = 1'b0;
            fd_exp   = (cur_idx == 3);
            if (fault_burst) fault_done = 1'b1;
            fault_burst = 1'b0;
          end else begin
            s_beat++;
          end
        end
        if (ar_hs) begin
          n_ar++;
          check("araddr", ar_addr_s, 32'(BASE + exp_idx * 128));
          if (ar_log_n < 8) ar_log[ar_log_n] = ar_addr_s;
          ar_log_n++;
          last_ar_addr = ar_addr_s;
          cur_idx  = exp_idx;
          exp_idx  = (exp_idx + 1) % 4;
          cur_addr = ar_addr_s;
          s_beat   = 0;
          s_active = 1'b1;
          ar_pop_snap = n_pops;
          fault_burst = cfg_fault_once;
          cfg_fault_once = 1'b0;
        end
      end
      m_axi_arready = arready_ctl;
      if (s_active) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = pack_pixels(cur_addr[15:8], cur_addr[7:0], 8'(s_beat), ~cur_addr[7:0], 8'h5A, 8'(n_ar));
        m_axi_rresp  = (fault_burst && s_beat == 5) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        m_axi_rlast  = (s_beat == (fault_burst ? 14 : 15));
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = AXI_RESP_OKAY;
        m_axi_rlast  = 1'b0;
      end
    end
  end

  // Stream monitor: compares every accepted output beat and every frame_done pulse.
  initial begin : monitor
    beat_t act_b;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (frame_done) n_fd++;
        if (frame_done || fd_exp) check("frame_done", 66'(frame_done), 66'(fd_exp));
        if (m_axis_tvalid && m_axis_tready) begin
          n_pops++;
          act_b = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_beat: got %0h, none expected", act_b);
          end else begin
            check("stream_beat", act_b, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic quiesce();
    int idle = 0;
    enable = 1'b0;
    for (int i = 0; i < 600 && idle < 4; i++) begin
      step();
      if (!m_axi_arvalid && !m_axi_rready && !m_axis_tvalid && !s_active) idle++;
      else idle = 0;
    end
    check("quiesce", 66'(idle >= 4), 66'd1);
  endtask

  initial begin : main
    int ar0, b0, p0, i;
    logic [31:0] a0;
    bit stable;

    step(3);
    check("rst_arvalid", 66'(m_axi_arvalid), 66'd0);
    check("rst_rready", 66'(m_axi_rready), 66'd0);
    check("rst_tvalid", 66'(m_axis_tvalid), 66'd0);
    check("rst_frame_done", 66'(frame_done), 66'd0);
    check("rst_err", 66'(err_status), 66'd0);
    check("rst_araddr", 66'(m_axi_araddr), 66'h1000_0000);
    check("arlen", 66'(m_axi_arlen), 66'd15);
    check("arsize", 66'(m_axi_arsize), 66'd3);
    check("arburst", 66'(m_axi_arburst), 66'd1);
    areset = 1'b0;

    // Continuous streaming: four bursts per frame, then wrap.
    enable = 1'b1;
    for (i = 0; i < 2000 && n_ar < 5; i++) step();
    check("t1_ar_count", 66'(n_ar >= 5), 66'd1);
    check("t1_addr0", 66'(ar_log[0]), 66'h1000_0000);
    check("t1_addr1", 66'(ar_log[1]), 66'h1000_0080);
    check("t1_addr2", 66'(ar_log[2]), 66'h1000_0100);
    check("t1_addr3", 66'(ar_log[3]), 66'h1000_0180);
    check("t1_addr4", 66'(ar_log[4]), 66'h1000_0000);
    check("t1_frames", 66'(n_fd), 66'd1);

    // Stalled stream: FIFO absorbs exactly two bursts.
    quiesce();
    ar0 = n_ar; b0 = n_rbeats;
    m_axis_tready = 1'b0;
    enable = 1'b1;
    step(100);
    check("t2_ar_count", 66'(n_ar - ar0), 66'd2);
    check("t2_beats", 66'(n_rbeats - b0), 66'd32);
    check("t2_no_arvalid", 66'(m_axi_arvalid), 66'd0);
    p0 = n_pops;
    m_axis_tready = 1'b1;
    for (i = 0; i < 300 && n_ar <= ar0 + 2; i++) step();
    check("t2_third_ar", 66'(n_ar > ar0 + 2), 66'd1);
    check("t2_pops_before_ar", 66'(ar_pop_snap - p0 >= 16), 66'd1);

    // Address channel back-pressure.
    quiesce();
    arready_ctl = 1'b0;
    ar0 = n_ar;
    enable = 1'b1;
    for (i = 0; i < 50 && !m_axi_arvalid; i++) step();
    check("t3_arvalid_up", 66'(m_axi_arvalid), 66'd1);
    a0 = m_axi_araddr;
    stable = 1'b1;
    for (i = 0; i < 20; i++) begin
      step();
      if (!m_axi_arvalid || m_axi_araddr !== a0) stable = 1'b0;
    end
    check("t3_stable", 66'(stable), 66'd1);
    check("t3_no_hs", 66'(n_ar - ar0), 66'd0);
    arready_ctl = 1'b1;
    step(2);
    check("t3_one_hs", 66'(n_ar - ar0), 66'd1);
    check("t3_hs_addr", 66'(last_ar_addr), 66'(a0));

    // SLVERR on beat 5 and early rlast on beat 14.
    fault_done = 1'b0;
    cfg_fault_once = 1'b1;
    for (i = 0; i < 400 && !fault_done; i++) step();
    check("t4_fault_seen", 66'(fault_done), 66'd1);
    step(2);
    check("t4_err", 66'(err_status), 66'b11);

    // Reset in the middle of a burst with data pending on the stream.
    for (i = 0; i < 200 && !(m_axi_rready && m_axis_tvalid); i++) step();
    check("t6_midburst", 66'(m_axi_rready && m_axis_tvalid), 66'd1);
    areset = 1'b1;
    enable = 1'b0;
    step();
    check("t6_tvalid", 66'(m_axis_tvalid), 66'd0);
    check("t6_arvalid", 66'(m_axi_arvalid), 66'd0);
    check("t6_araddr", 66'(m_axi_araddr), 66'h1000_0000);
    check("t6_err", 66'(err_status), 66'd0);
    areset = 1'b0;
    step(2);

    // Enable dropped at beat 7 of burst 2; burst finishes, fetch resumes at the next address.
    ar0 = n_ar;
    enable = 1'b1;
    for (i = 0; i < 300 && !(n_ar == ar0 + 2 && s_active && s_beat == 7); i++) step();
    check("t5_at_beat7", 66'(n_ar == ar0 + 2 && s_beat == 7), 66'd1);
    enable = 1'b0;
    step(60);
    check("t5_ar_count", 66'(n_ar - ar0), 66'd2);
    check("t5_addr2", 66'(last_ar_addr), 66'h1000_0080);
    check("t5_parked", 66'(m_axi_arvalid || m_axi_rready), 66'd0);
    enable = 1'b1;
    for (i = 0; i < 100 && n_ar < ar0 + 3; i++) step();
    check("t5_resume_addr", 66'(last_ar_addr), 66'h1000_0100);

    quiesce();
    check("drained", 66'(exp_q.size()), 66'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
